dmem_bank: RTL
==============

# dmem_bank

Parametrised, byte-addressed data memory for the RISC-V core's load/store stage. Replaces the word-addressed, word-only data memory with RISC-V sub-word access (byte/half/word/double, signed and unsigned loads), byte-enable stores, and alignment/range error reporting. Requests use a valid/ready handshake. Responses leave a registered output stage with backpressure.

## Interface
- DATA_W, 32: memory word width. Legal values are 32 and 64.
- DEPTH, 1024: number of DATA_W-wide words.
- ADDR_W, 32: byte-address width.
- INIT_FILE, "": hex image loaded with $readmemh at time zero. An empty string means no preload.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is present.
- req_ready  out  1  the block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_funct3  in  3  RISC-V funct3 access size and signedness.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  a response is present.
- rsp_ready  in  1  the consumer takes the response.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors.
- rsp_err  out  1  the request was misaligned, out of range, or had an illegal funct3.

## Operation
- Request accept: occurs when req_valid && req_ready. req_ready = !rsp_valid || rsp_ready, so at most one response is outstanding.
- Address split: OFF_W = log2(DATA_W/8). Byte offset = req_addr[OFF_W-1:0]. Word index = req_addr >> OFF_W.
- Legal funct3 values:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - When DATA_W=64 only: 011 LD/SD and 110 LWU.
  - 100, 101 and 110 with req_we=1 are illegal.
- Error conditions, any of which sets rsp_err=1:
  - illegal funct3;
  - misalignment: half needs offset[0]=0, word needs offset[1:0]=0, double needs offset[2:0]=0;
  - word index >= DEPTH.
- Error side effects: on any error the memory is not written, and rsp_rdata=0.
- Store: byte enables cover size bytes starting at the offset lane. Store data is the low size bytes of req_wdata, shifted left by offset*8. The array is written on the accept edge.
- Load: the selected word is read on the accept edge and shifted right by offset*8. The result is masked to size and then sign-extended (signed funct3) or zero-extended (unsigned funct3) to DATA_W.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 or later. Two requests are never accepted on the same edge.
- Reset effects: rsp_valid, rsp_rdata and rsp_err are cleared. Array contents are not cleared.
- Preload: INIT_FILE is applied once at time zero. Its addressing is word-granular: line k goes to word k.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=1 (combinational while reset is deasserted).
- Latency: a request accepted at edge N gives a response with rsp_valid=1 after edge N, held until the rsp_ready edge.
- Throughput: with rsp_ready held at 1, one request is accepted per cycle and one response is produced per cycle, with no bubbles.
- Response stall: while rsp_valid && !rsp_ready, req_ready=0 and rsp_rdata/rsp_err stay stable.
- Response pop and new accept on the same edge: the response register loads the new result and rsp_valid stays 1.
- Response pop with no new request: rsp_valid goes to 0 on that edge.
- Reset mid-operation: asserting reset drops rsp_valid immediately (asynchronous), discarding the pending response. A store already accepted remains in the array. Deassertion is synchronised externally; the first accept can happen on the first edge after deassertion.
- Memory read port: synchronous. There is no combinational path from req_* to rsp_*. The only combinational path is rsp_ready to req_ready.

## Test plan
- Store then load, DATA_W=32: SW 0xDEADBEEF at addr 0x10, then LW 0x10. Required: rsp_rdata=0xDEADBEEF, err=0, one response per cycle with rsp_ready=1.
- Sub-word extension: after the store above, the following loads must return:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
- Byte-enable store: SB 0x55 at 0x11 over 0xDEADBEEF, then LW 0x10. Required: 0xDEAD55EF; other words unchanged.
- Errors: LW 0x12, SH 0x21, LW at DEPTH*4, and funct3=111 each give err=1 and rdata=0. A later LW of each target word shows contents unchanged.
- Backpressure and reset: hold rsp_ready=0 for 3 cycles with the response pending. Required: req_ready=0 and the response stable for those 3 cycles. Then pulse reset low mid-stall. Required: rsp_valid=0 immediately, and previously stored data is still readable after reset.
- DATA_W=64: SD 0x0123456789ABCDEF at 0x8, then:
  - LD 0x8 -> 0x0123456789ABCDEF
  - LW 0xC -> 0x0000000001234567
  - LWU 0x8 -> 0x0000000089ABCDEF

Source files
------------

// File: rtl/dmem_bank.sv
// dmem_bank: byte-addressed data memory for the load/store stage.
// Sub-word loads and stores, error reporting, registered response with backpressure.
module dmem_bank #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              legal;
    logic              misal;
    logic              in_rng;
    logic              err;
    logic [1:0]        sz;
    logic              sgn;
    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  widx;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wd_sh;

    logic [DATA_W-1:0] rd_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        sz_q;
    logic              sgn_q;
    logic              rsp_ok;

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ld_val;
    logic              ext;
    int                nbits;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[OFF_W-1:0];
    assign word_idx  = req_addr >> OFF_W;
    assign widx      = word_idx[IDX_W-1:0];
    assign in_rng    = word_idx < ADDR_W'(DEPTH);

    // sz is log2 of the access size in bytes
    always_comb begin
        sz    = 2'd0;
        sgn   = 1'b1;
        legal = 1'b1;
        case (req_funct3)
            3'b000: sz = 2'd0;
            3'b001: sz = 2'd1;
            3'b010: sz = 2'd2;
            3'b011: begin
                sz    = 2'd3;
                legal = (DATA_W == 64);
            end
            3'b100: begin
                sgn   = 1'b0;
                legal = !req_we;
            end
            3'b101: begin
                sz    = 2'd1;
                sgn   = 1'b0;
                legal = !req_we;
            end
            3'b110: begin
                sz    = 2'd2;
                sgn   = 1'b0;
                legal = (DATA_W == 64) && !req_we;
            end
            default: legal = 1'b0;
        endcase
    end

    assign misal = |(off & OFF_W'((32'd1 << sz) - 32'd1));
    assign err   = !legal || misal || !in_rng;

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(off)) && (b < int'(off) + (1 << sz));
        end
        wd_sh = req_wdata << {off, 3'b000};
    end

    // Array port: byte-enable write and registered read, no reset
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[widx][b*8 +: 8] <= wd_sh[b*8 +: 8];
                end
            end
        end
        if (accept) begin
            rd_q <= mem[widx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_ok    <= 1'b0;
            off_q     <= '0;
            sz_q      <= 2'd0;
            sgn_q     <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_ok    <= !err && !req_we;
            off_q     <= off;
            sz_q      <= sz;
            sgn_q     <= sgn;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Align, mask and extend the registered word; zero for stores/errors
    always_comb begin
        sh    = rd_q >> {off_q, 3'b000};
        nbits = 8 << sz_q;
        case (sz_q)
            2'd0:    ext = sh[7];
            2'd1:    ext = sh[15];
            2'd2:    ext = sh[31];
            default: ext = sh[DATA_W-1];
        endcase
        ext = ext & sgn_q;
        for (int i = 0; i < DATA_W; i++) begin
            ld_val[i] = (i < nbits) ? sh[i] : ext;
        end
        rsp_rdata = rsp_ok ? ld_val : '0;
    end

endmodule
